// File: rtl/intr_sched_if.sv
// Interrupt scheduler bus: source lines, core trap handshake and status.
// slave = scheduler side, master = core/source side.
interface intr_sched_if #(
  parameter int NUM_SRC = 4,
  parameter int CAUSE_W = 5
) ();

  logic [NUM_SRC-1:0] i_intr_h;
  logic [NUM_SRC-1:0] i_int_mask;
  logic               mie_bit;
  logic               stop_fetch;
  logic               jump;
  logic               i_trap_take;
  logic               i_mret;
  logic               o_trap_req;
  logic [CAUSE_W-1:0] o_trap_cause;
  logic [NUM_SRC-1:0] o_int_ack;
  logic               o_in_service;
  logic               o_int_en;

  modport slave (
    input  i_intr_h,
    input  i_int_mask,
    input  mie_bit,
    input  stop_fetch,
    input  jump,
    input  i_trap_take,
    input  i_mret,
    output o_trap_req,
    output o_trap_cause,
    output o_int_ack,
    output o_in_service,
    output o_int_en
  );

  modport master (
    output i_intr_h,
    output i_int_mask,
    output mie_bit,
    output stop_fetch,
    output jump,
    output i_trap_take,
    output i_mret,
    input  o_trap_req,
    input  o_trap_cause,
    input  o_int_ack,
    input  o_in_service,
    input  o_int_en
  );

endinterface

// File: rtl/intr_sched.sv
// Interrupt scheduler: masks, arbitrates and presents one trap to the core,
// acks the winner and blocks nesting until mret.
module intr_sched #(
  parameter int NUM_SRC    = 4,
  parameter int IDX_W      = 2,
  parameter int CAUSE_W    = 5,
  parameter int CAUSE_BASE = 16,
  parameter int RR_MODE    = 0
) (
  input  logic         clk,
  input  logic         rst,
  intr_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK     = 2'd2,
    SERVICE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SRC-1:0] eligible;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               req_q;
  logic               svc_q;

  logic               arb_hit;
  logic [IDX_W-1:0]   arb_idx;
  logic               withdraw;
  logic               commit;

  assign eligible = bus.i_intr_h & bus.i_int_mask;
  assign bus.o_int_en = |eligible;

  // Scan starts at rr_ptr in round-robin mode, at 0 otherwise.
  always_comb begin
    int k;
    logic [IDX_W-1:0] kk;
    k       = 0;
    kk      = '0;
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      if (RR_MODE != 0)
        k = (int'(rr_ptr_q) + off) % NUM_SRC;
      else
        k = off;
      kk = IDX_W'(k);
      if (!arb_hit && eligible[kk]) begin
        arb_hit = 1'b1;
        arb_idx = kk;
      end
    end
  end

  assign withdraw = !eligible[win_q] || !bus.mie_bit;
  assign commit   = bus.i_trap_take && !bus.stop_fetch && !bus.jump;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cause_d  = cause_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mie_bit && arb_hit) begin
          state_d = REQ;
          win_d   = arb_idx;
          cause_d = CAUSE_W'(CAUSE_BASE + int'(arb_idx));
        end
      end
      REQ: begin
        if (withdraw) begin
          state_d = IDLE;
        end else if (commit) begin
          state_d = ACK;
          if (RR_MODE != 0)
            rr_ptr_d = IDX_W'((int'(win_q) + 1) % NUM_SRC);
        end
      end
      ACK: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (bus.i_mret)
          state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ack_d = '0;
    if (state_d == ACK)
      ack_d[win_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      win_q    <= '0;
      cause_q  <= '0;
      rr_ptr_q <= '0;
      req_q    <= 1'b0;
      ack_q    <= '0;
      svc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cause_q  <= cause_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= (state_d == REQ);
      ack_q    <= ack_d;
      svc_q    <= (state_d == ACK) || (state_d == SERVICE);
    end
  end

  assign bus.o_trap_req   = req_q;
  assign bus.o_trap_cause = cause_q;
  assign bus.o_int_ack    = ack_q;
  assign bus.o_in_service = svc_q;

endmodule

// File: doc/intr_sched.md
Name: intr_sched

Overview:
- Interrupt scheduler sitting between the external interrupt lines and the core's trap-entry logic.
- Masks and arbitrates up to NUM_SRC level-sensitive requests by fixed priority or round-robin.
- Presents one trap request with cause to the core and holds it until the core commits at a safe boundary (no stop_fetch, no jump).
- Pulses a one-hot ack to the winning source, then blocks further arbitration until the core executes mret.

Parameters:
NUM_SRC, 4, number of interrupt sources (2..16)
IDX_W, 2, width of the source index; must equal clog2(NUM_SRC)
CAUSE_W, 5, width of o_trap_cause
CAUSE_BASE, 16, cause code of source 0; source k reports CAUSE_BASE+k
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
i_intr_h  in  NUM_SRC  level interrupt requests, one bit per source
i_int_mask  in  NUM_SRC  per-source enable (1 = enabled)
mie_bit  in  1  global interrupt enable from mstatus
stop_fetch  in  1  pipeline stall; trap entry forbidden while high
jump  in  1  control transfer in flight; trap entry forbidden while high
i_trap_take  in  1  core accepts the presented trap this cycle
i_mret  in  1  core retires mret this cycle
o_trap_req  out  1  trap request to the core
o_trap_cause  out  CAUSE_W  cause code, valid while o_trap_req=1
o_int_ack  out  NUM_SRC  one-hot, single-cycle acknowledge to the serviced source
o_in_service  out  1  a trap is being serviced; nesting blocked
o_int_en  out  1  combinational OR of (i_intr_h & i_int_mask)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; o_trap_req=0, o_trap_cause=0, o_int_ack=0, o_in_service=0; rr_ptr=0, winner=0.
- Reset asserted mid-operation aborts any request or service in progress. No ack is issued.
- All outputs except o_int_en are registered.
- eligible = i_intr_h & i_int_mask.
- Arbitration in fixed mode: lowest set index of eligible wins.
- Arbitration in round-robin mode: first set index at or above rr_ptr wins, wrapping modulo NUM_SRC.
- State IDLE:
  - If mie_bit=1 and eligible!=0, register winner and cause; go to REQ.
  - o_trap_req=1 in the next cycle, so there is 1 cycle from request to o_trap_req.
- State REQ (o_trap_req=1; cause held stable, no re-arbitration):
  - Withdraw: if eligible[winner]=0 or mie_bit=0, go to IDLE with o_trap_req=0 next cycle. A higher-priority arrival does not preempt.
  - Commit: if i_trap_take=1, stop_fetch=0 and jump=0, go to ACK. If i_trap_take=1 while stop_fetch or jump is high, ignore it and stay in REQ.
  - Withdraw has precedence over commit in the same cycle.
- State ACK:
  - o_int_ack[winner]=1 for exactly one cycle; o_trap_req=0; o_in_service=1.
  - Next state is SERVICE.
  - In round-robin mode, rr_ptr = (winner+1) mod NUM_SRC at this edge.
- State SERVICE:
  - o_in_service=1; no arbitration.
  - On i_mret=1, go to IDLE with o_in_service=0 next cycle.
  - A pending request may re-enter REQ no earlier than 1 cycle after reaching IDLE.
- i_mret outside SERVICE is ignored.
- i_trap_take outside REQ is ignored.
- Cause arithmetic: CAUSE_BASE + winner, zero-extended to CAUSE_W, truncated modulo 2^CAUSE_W.
- Illegal or unused state encodings go to IDLE.

Test Plan:
1. Fixed mode, i_intr_h=4'b0110, mask=4'hF, mie=1; i_trap_take at cycle 3 -> o_trap_req=1 from cycle 1, cause=17; o_int_ack=4'b0010 for one cycle at cycle 4; o_in_service=1 until the cycle after i_mret.
2. i_trap_take held high with stop_fetch=1 for 3 cycles, then jump=1 for 2 cycles, then both low -> no ack until stop_fetch=0 and jump=0 in the same cycle; exactly one ack pulse.
3. In REQ, drop i_intr_h[winner] (or mie_bit) -> o_trap_req falls next cycle, state IDLE, o_int_ack stays 0; in the same cycle as i_trap_take, withdraw wins.
4. Round-robin, all four sources held high, immediate take and mret each round -> acks in order 0001, 0010, 0100, 1000, 0001.
5. Mask 4'b0101 with i_intr_h=4'b1010 -> o_int_en=0, no request; set mask bit 1 -> cause=17 is presented.
6. Assert rst for 1 cycle during SERVICE, and separately during REQ -> all outputs 0 next cycle, rr_ptr=0, no ack; a still-pending request re-arbitrates normally afterwards.
